// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - EX-stage branch resolution, redirect/squash, 2-bit BHT and perf counters
module branch_resolve_unit #(
    parameter int IDX_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    input  logic             stall,
    input  logic [31:0]      ex_pc,
    input  logic [6:0]       ex_opcode,
    input  logic [2:0]       ex_funct3,
    input  logic             br_eq,
    input  logic             br_lt,
    input  logic             br_ltu,
    input  logic [31:0]      ex_br_target,
    input  logic [31:0]      ex_jalr_target,
    input  logic             ex_pred_taken,
    input  logic [31:0]      if_pc,
    output logic             pred_taken,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             illegal_br,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mispred_count
);

    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_SQUASH = 1'b1;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam int ENTRIES = 1 << IDX_W;

    logic [0:0]       state;
    logic [1:0]       bht [ENTRIES];
    logic [IDX_W-1:0] ex_idx;
    logic [IDX_W-1:0] if_idx;
    logic             accept;
    logic             is_br;
    logic             is_jal;
    logic             is_jalr;
    logic             f3_illegal;
    logic             br_legal;
    logic             taken;
    logic             mispred;
    logic             redirect_gen;
    logic [31:0]      redirect_nxt;
    logic [1:0]       bht_cur;
    logic [1:0]       bht_nxt;
    logic             unused_pc_bits;

    assign ex_idx = ex_pc[IDX_W+1:2];
    assign if_idx = if_pc[IDX_W+1:2];
    assign unused_pc_bits = ^{if_pc[31:IDX_W+2], if_pc[1:0]};

    // Wrong-path slot following a redirect is never consumed.
    assign accept = ex_valid & ~stall & (state == ST_RUN);

    assign is_br      = (ex_opcode == OP_BRANCH);
    assign is_jal     = (ex_opcode == OP_JAL);
    assign is_jalr    = (ex_opcode == OP_JALR);
    assign f3_illegal = (ex_funct3 == 3'b010) || (ex_funct3 == 3'b011);
    assign br_legal   = is_br & ~f3_illegal;

    always_comb begin
        taken = 1'b0;
        case (ex_funct3)
            3'b000:  taken = br_eq;
            3'b001:  taken = ~br_eq;
            3'b100:  taken = br_lt;
            3'b101:  taken = ~br_lt;
            3'b110:  taken = br_ltu;
            3'b111:  taken = ~br_ltu;
            default: taken = 1'b0;
        endcase
    end

    assign mispred      = br_legal & (taken != ex_pred_taken);
    assign redirect_gen = accept & (mispred | is_jal | is_jalr);

    always_comb begin
        redirect_nxt = ex_pc + 32'd4;
        if (is_jal)
            redirect_nxt = ex_br_target;
        else if (is_jalr)
            redirect_nxt = ex_jalr_target;
        else if (taken)
            redirect_nxt = ex_br_target;
    end

    assign bht_cur = bht[ex_idx];

    always_comb begin
        bht_nxt = bht_cur;
        if (taken) begin
            if (bht_cur != 2'b11)
                bht_nxt = bht_cur + 2'b01;
        end else begin
            if (bht_cur != 2'b00)
                bht_nxt = bht_cur - 2'b01;
        end
    end

    // Read is from the registered table, so a same-cycle update is not visible yet.
    assign pred_taken = bht[if_idx][1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++)
                bht[i] <= 2'b01;
        end else if (accept && br_legal) begin
            bht[ex_idx] <= bht_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else begin
            case (state)
                ST_RUN:    if (redirect_gen) state <= ST_SQUASH;
                ST_SQUASH: if (!stall)       state <= ST_RUN;
                default:                     state <= ST_RUN;
            endcase
        end
    end

    // Pulses are rewritten every edge so they last exactly one cycle regardless of stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'd0;
            illegal_br     <= 1'b0;
        end else begin
            redirect_valid <= redirect_gen;
            illegal_br     <= accept & is_br & f3_illegal;
            if (redirect_gen)
                redirect_pc <= redirect_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_count      <= '0;
            mispred_count <= '0;
        end else if (accept && br_legal) begin
            br_count <= br_count + CNT_W'(1);
            if (mispred)
                mispred_count <= mispred_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - directed table and sequence bench for branch_resolve_unit
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic        stall;
    logic [31:0] ex_pc;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_funct3;
    logic        br_eq, br_lt, br_ltu;
    logic [31:0] ex_br_target;
    logic [31:0] ex_jalr_target;
    logic        ex_pred_taken;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        illegal_br;
    logic [15:0] br_count;
    logic [15:0] mispred_count;

    int total = 0;
    int bad   = 0;

    localparam logic [6:0] BR   = 7'b1100011;
    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] JALR = 7'b1100111;
    localparam logic [6:0] OPR  = 7'b0110011;

    branch_resolve_unit #(.IDX_W(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .stall(stall),
        .ex_pc(ex_pc), .ex_opcode(ex_opcode), .ex_funct3(ex_funct3),
        .br_eq(br_eq), .br_lt(br_lt), .br_ltu(br_ltu),
        .ex_br_target(ex_br_target), .ex_jalr_target(ex_jalr_target),
        .ex_pred_taken(ex_pred_taken), .if_pc(if_pc), .pred_taken(pred_taken),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .illegal_br(illegal_br), .br_count(br_count), .mispred_count(mispred_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        eq, lt, ltu, pred;
        logic [31:0] pc, tgt, jtgt;
        logic        exp_rv;
        logic [31:0] exp_pc;
        logic        exp_ill;
        logic        exp_cond;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        ex_valid = 0; stall = 0; ex_pc = 0; ex_opcode = 0; ex_funct3 = 0;
        br_eq = 0; br_lt = 0; br_ltu = 0; ex_br_target = 0; ex_jalr_target = 0;
        ex_pred_taken = 0; if_pc = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic eq, input logic lt,
                         input logic ltu, input logic pred, input logic [31:0] pc,
                         input logic [31:0] tgt, input logic [31:0] jtgt);
        ex_valid = 1; ex_opcode = op; ex_funct3 = f3; br_eq = eq; br_lt = lt; br_ltu = ltu;
        ex_pred_taken = pred; ex_pc = pc; ex_br_target = tgt; ex_jalr_target = jtgt;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int exp_br;
        int exp_mis;

        vecs[0]  = '{BR,   3'b000, 0, 0, 0, 0, 32'h200, 32'h300, 0, 0, 0,          0, 1};
        vecs[1]  = '{BR,   3'b001, 0, 0, 0, 0, 32'h200, 32'h300, 0, 1, 32'h300,    0, 1};
        vecs[2]  = '{BR,   3'b100, 0, 1, 0, 1, 32'h204, 32'h350, 0, 0, 0,          0, 1};
        vecs[3]  = '{BR,   3'b101, 0, 1, 0, 1, 32'h204, 32'h350, 0, 1, 32'h208,    0, 1};
        vecs[4]  = '{BR,   3'b110, 0, 0, 0, 1, 32'h408, 32'h600, 0, 1, 32'h40C,    0, 1};
        vecs[5]  = '{BR,   3'b111, 0, 0, 0, 0, 32'h40C, 32'h500, 0, 1, 32'h500,    0, 1};
        vecs[6]  = '{BR,   3'b010, 1, 1, 1, 0, 32'h410, 32'h700, 0, 0, 0,          1, 0};
        vecs[7]  = '{BR,   3'b011, 1, 1, 1, 0, 32'h414, 32'h700, 0, 0, 0,          1, 0};
        vecs[8]  = '{JAL,  3'b000, 0, 0, 0, 1, 32'h418, 32'h1234, 32'h9999, 1, 32'h1234, 0, 0};
        vecs[9]  = '{JALR, 3'b000, 0, 0, 0, 0, 32'h41C, 32'h1111, 32'h2468, 1, 32'h2468, 0, 0};
        vecs[10] = '{OPR,  3'b000, 1, 1, 1, 0, 32'h420, 32'h800, 32'h900, 0, 0,      0, 0};
        vecs[11] = '{BR,   3'b000, 1, 0, 0, 1, 32'h424, 32'h880, 0, 0, 0,          0, 1};

        // Reset state and full BHT sweep
        do_reset();
        chk("rst_redirect_valid", redirect_valid, 0);
        chk("rst_redirect_pc", redirect_pc, 0);
        chk("rst_illegal_br", illegal_br, 0);
        chk("rst_br_count", br_count, 0);
        chk("rst_mispred_count", mispred_count, 0);
        for (int i = 0; i < 16; i++) begin
            if_pc = 32'(i * 4);
            #1;
            chk($sformatf("rst_pred_idx%0d", i), pred_taken, 0);
        end

        // BEQ mispredict, then BNE in the squash slot is ignored
        @(negedge clk);
        drive(BR, 3'b000, 1, 0, 0, 0, 32'h100, 32'h80, 0);
        @(posedge clk); #1;
        drive(BR, 3'b001, 0, 0, 0, 0, 32'h104, 32'h180, 0);
        @(negedge clk);
        chk("beq_redirect_valid", redirect_valid, 1);
        chk("beq_redirect_pc", redirect_pc, 32'h80);
        chk("beq_mispred", mispred_count, 1);
        chk("beq_br", br_count, 1);
        @(posedge clk); #1;
        ex_valid = 0;
        @(negedge clk);
        chk("beq_pulse_end", redirect_valid, 0);
        chk("squash_ignored_br", br_count, 1);
        chk("squash_ignored_mis", mispred_count, 1);

        // BGEU wrap and BHT[15] decrement to 00
        do_reset();
        drive(BR, 3'b111, 0, 0, 1, 1, 32'hFFFFFFFC, 32'h10, 0);
        @(posedge clk); #1;
        ex_valid = 0;
        @(negedge clk);
        chk("bgeu_redirect_valid", redirect_valid, 1);
        chk("bgeu_wrap_pc", redirect_pc, 32'h0);
        @(posedge clk);
        @(negedge clk);
        drive(BR, 3'b000, 1, 0, 0, 0, 32'h3C, 32'h44, 0);
        @(posedge clk); #1;
        ex_valid = 0;
        @(negedge clk);
        chk("idx15_redirect_pc", redirect_pc, 32'h44);
        if_pc = 32'h3C; #1;
        chk("idx15_after_dec_inc", pred_taken, 0);
        chk("idx15_br", br_count, 2);
        @(posedge clk);
        @(negedge clk);

        // Three taken BLTs train index 0 up to saturation
        do_reset();
        if_pc = 32'h40;
        drive(BR, 3'b100, 0, 1, 0, 1, 32'h40, 32'hA0, 0);
        #1;
        chk("blt_pred_before", pred_taken, 0);
        @(posedge clk);
        @(negedge clk);
        chk("blt1_pred", pred_taken, 1);
        chk("blt1_no_redirect", redirect_valid, 0);
        @(posedge clk);
        @(negedge clk);
        chk("blt2_no_redirect", redirect_valid, 0);
        @(posedge clk); #1;
        ex_valid = 0;
        @(negedge clk);
        chk("blt3_no_redirect", redirect_valid, 0);
        chk("blt3_pred", pred_taken, 1);
        chk("blt3_br", br_count, 3);
        chk("blt3_mis", mispred_count, 0);
        drive(BR, 3'b100, 0, 0, 0, 1, 32'h40, 32'hA0, 0);
        @(posedge clk); #1;
        ex_valid = 0;
        @(negedge clk);
        chk("blt_nt_redirect_pc", redirect_pc, 32'h44);
        chk("blt_sat_pred", pred_taken, 1);
        @(posedge clk);
        @(negedge clk);

        // JALR held off by stall, pulse survives a stall in its own cycle
        do_reset();
        drive(JALR, 3'b000, 0, 0, 0, 0, 32'h500, 32'h777, 32'h2000);
        stall = 1;
        @(posedge clk);
        @(negedge clk);
        chk("jalr_stall1", redirect_valid, 0);
        @(posedge clk);
        @(negedge clk);
        chk("jalr_stall2", redirect_valid, 0);
        stall = 0;
        @(posedge clk); #1;
        ex_valid = 0;
        stall = 1;
        @(negedge clk);
        chk("jalr_redirect_valid", redirect_valid, 1);
        chk("jalr_redirect_pc", redirect_pc, 32'h2000);
        chk("jalr_br_count", br_count, 0);
        @(posedge clk);
        @(negedge clk);
        chk("jalr_pulse_end_stalled", redirect_valid, 0);
        stall = 0;
        @(posedge clk);
        @(negedge clk);

        // Decode table
        do_reset();
        exp_br = 0;
        exp_mis = 0;
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].op, vecs[i].f3, vecs[i].eq, vecs[i].lt, vecs[i].ltu, vecs[i].pred,
                  vecs[i].pc, vecs[i].tgt, vecs[i].jtgt);
            @(posedge clk); #1;
            ex_valid = 0;
            if (vecs[i].exp_cond) begin
                exp_br++;
                if (vecs[i].exp_rv) exp_mis++;
            end
            @(negedge clk);
            chk($sformatf("vec%0d_redirect_valid", i), redirect_valid, vecs[i].exp_rv);
            if (vecs[i].exp_rv)
                chk($sformatf("vec%0d_redirect_pc", i), redirect_pc, vecs[i].exp_pc);
            chk($sformatf("vec%0d_illegal_br", i), illegal_br, vecs[i].exp_ill);
            chk($sformatf("vec%0d_br_count", i), br_count, 32'(exp_br));
            chk($sformatf("vec%0d_mispred_count", i), mispred_count, 32'(exp_mis));
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("vec%0d_pulses_end", i), {redirect_valid, illegal_br}, 0);
        end

        // Reset during SQUASH, then immediate acceptance
        drive(JAL, 3'b000, 0, 0, 0, 0, 32'h600, 32'h4000, 0);
        @(posedge clk); #1;
        ex_valid = 0;
        @(negedge clk);
        chk("jal_redirect_valid", redirect_valid, 1);
        rst_n = 0;
        #1;
        chk("midsquash_rst_rv", redirect_valid, 0);
        chk("midsquash_rst_pc", redirect_pc, 0);
        chk("midsquash_rst_br", br_count, 0);
        @(negedge clk);
        rst_n = 1;
        drive(BR, 3'b000, 1, 0, 0, 0, 32'h10, 32'h90, 0);
        @(posedge clk); #1;
        ex_valid = 0;
        @(negedge clk);
        chk("post_rst_redirect_valid", redirect_valid, 1);
        chk("post_rst_redirect_pc", redirect_pc, 32'h90);
        chk("post_rst_br", br_count, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
